// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: condition encodings,
// NZCV bit positions and IT-sequencer states.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: maps a 4-bit condition code and the
// NZCV flags to a single execute/skip decision.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       ex
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Standard condition decode; NV never executes.
   always_comb begin
      ex = 1'b0;
      case (cond_e'(cond))
         EQ:      ex = z;
         NE:      ex = ~z;
         CS:      ex = c;
         CC:      ex = ~c;
         MI:      ex = n;
         PL:      ex = ~n;
         VS:      ex = v;
         VC:      ex = ~v;
         HI:      ex = c & ~z;
         LS:      ex = ~c | z;
         GE:      ex = (n == v);
         LT:      ex = (n != v);
         GT:      ex = ~z & (n == v);
         LE:      ex = z | (n != v);
         AL:      ex = 1'b1;
         NV:      ex = 1'b0;
         default: ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit_it.sv
// Execute-stage conditional unit: banked NZCV flags with split write enables,
// an IT-block sequencer predicating following instructions, and write gating.
module cond_unit_it
   import cond_pkg::*;
#(
   parameter  int NBANKS = 2,
   parameter  int IT_MAX = 4,
   localparam int LEN_W  = $clog2(IT_MAX + 1),
   localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic [BANK_W-1:0] bank_i,
   input  logic [3:0]        Cond,
   input  logic [3:0]        ALUFlags,
   input  logic [1:0]        FlagW,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              it_start,
   input  logic [LEN_W-1:0]  it_len,
   input  logic [IT_MAX-1:0] it_mask,
   input  logic [3:0]        it_cond,
   input  logic              flush,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx,
   output logic              it_active,
   output logic              it_err,
   output logic [3:0]        flags_o
);

   logic [3:0]        flags_q [NBANKS];
   it_state_e         state_q;
   it_state_e         state_d;
   logic [LEN_W-1:0]  count_q;
   logic [LEN_W-1:0]  count_d;
   logic [IT_MAX-1:0] mask_q;
   logic [IT_MAX-1:0] mask_d;
   logic [3:0]        cond_q;
   logic [3:0]        cond_d;
   logic              err_q;
   logic              err_d;

   logic              bank_ok;
   logic [3:0]        cur_flags;
   logic [3:0]        eff_cond;
   logic              ex;
   logic              cond_ex;
   logic              opener;
   logic              write_en;
   logic              accept;
   logic              len_ok;

   assign bank_ok   = (32'(bank_i) < NBANKS);
   assign cur_flags = bank_ok ? flags_q[bank_i] : 4'b0000;

   // Inside a block the shared condition is used directly or with its low bit
   // flipped, which turns AL into NV for "else" slots.
   assign eff_cond = (state_q == ACTIVE)
                   ? (mask_q[0] ? cond_q : {cond_q[3:1], ~cond_q[0]})
                   : Cond;

   cond_eval u_cond_eval (
      .cond  (eff_cond),
      .flags (cur_flags),
      .ex    (ex)
   );

   assign cond_ex  = valid_i & ~flush & ~reset & ex;
   assign opener   = (state_q == IDLE) & it_start;
   assign write_en = cond_ex & ~opener;
   assign accept   = valid_i & ~flush;
   assign len_ok   = (it_len != {LEN_W{1'b0}}) && (32'(it_len) <= IT_MAX);

   assign CondEx    = cond_ex;
   assign PCSrc     = PCS  & write_en;
   assign RegWrite  = RegW & write_en;
   assign MemWrite  = MemW & write_en;
   assign it_active = (state_q == ACTIVE);
   assign it_err    = err_q;
   assign flags_o   = cur_flags;

   // Flag banks: {N,Z} and {C,V} halves written independently.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NBANKS; b++) begin
            flags_q[b] <= 4'b0000;
         end
      end else if (bank_ok && write_en) begin
         if (FlagW[1]) begin
            flags_q[bank_i][3:2] <= ALUFlags[3:2];
         end
         if (FlagW[0]) begin
            flags_q[bank_i][1:0] <= ALUFlags[1:0];
         end
      end
   end

   // IT sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= {LEN_W{1'b0}};
         mask_q  <= {IT_MAX{1'b0}};
         cond_q  <= 4'b0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mask_q  <= mask_d;
         cond_q  <= cond_d;
         err_q   <= err_d;
      end
   end

   // IT sequencer next state; flush overrides everything else.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mask_d  = mask_q;
      cond_d  = cond_q;
      err_d   = 1'b0;
      if (flush) begin
         state_d = IDLE;
         count_d = {LEN_W{1'b0}};
         mask_d  = {IT_MAX{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && it_start) begin
                  if (!len_ok) begin
                     err_d = 1'b1;
                  end else if (cond_ex) begin
                     state_d = ACTIVE;
                     cond_d  = it_cond;
                     mask_d  = it_mask;
                     count_d = it_len;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            ACTIVE: begin
               if (accept) begin
                  err_d   = it_start;
                  count_d = count_q - LEN_W'(1);
                  mask_d  = mask_q >> 1;
                  if ((count_q == LEN_W'(1)) || PCSrc) begin
                     state_d = IDLE;
                     count_d = {LEN_W{1'b0}};
                     mask_d  = {IT_MAX{1'b0}};
                  end else begin
                     state_d = ACTIVE;
                  end
               end else begin
                  state_d = ACTIVE;
               end
            end
            default: begin
               state_d = IDLE;
               count_d = {LEN_W{1'b0}};
               mask_d  = {IT_MAX{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed self-checking bench for cond_unit_it (NBANKS=2, IT_MAX=4).
module tb_cond_unit_it;

   logic       clk;
   logic       reset;
   logic       valid_i;
   logic [0:0] bank_i;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       it_start;
   logic [2:0] it_len;
   logic [3:0] it_mask;
   logic [3:0] it_cond;
   logic       flush;
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic       CondEx;
   logic       it_active;
   logic       it_err;
   logic [3:0] flags_o;

   int total = 0;
   int bad   = 0;

   cond_unit_it #(.NBANKS(2), .IT_MAX(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (valid_i),
      .bank_i    (bank_i),
      .Cond      (Cond),
      .ALUFlags  (ALUFlags),
      .FlagW     (FlagW),
      .PCS       (PCS),
      .RegW      (RegW),
      .MemW      (MemW),
      .it_start  (it_start),
      .it_len    (it_len),
      .it_mask   (it_mask),
      .it_cond   (it_cond),
      .flush     (flush),
      .PCSrc     (PCSrc),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .CondEx    (CondEx),
      .it_active (it_active),
      .it_err    (it_err),
      .flags_o   (flags_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      valid_i  = 1'b0;
      bank_i   = 1'b0;
      Cond     = 4'b1110;
      ALUFlags = 4'b0000;
      FlagW    = 2'b00;
      PCS      = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
      it_start = 1'b0;
      it_len   = 3'd0;
      it_mask  = 4'b0000;
      it_cond  = 4'b0000;
      flush    = 1'b0;
   endtask

   task automatic opener(input logic [3:0] c, input logic [2:0] len, input logic [3:0] m);
      idle_in();
      valid_i  = 1'b1;
      it_start = 1'b1;
      Cond     = 4'b1110;
      it_cond  = c;
      it_len   = len;
      it_mask  = m;
   endtask

   task automatic slot(input logic regw);
      idle_in();
      valid_i = 1'b1;
      Cond    = 4'b1111;
      RegW    = regw;
   endtask

   initial begin
      idle_in();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_flags_b0", {4'h0, flags_o}, 8'h00);
      chk("rst_active", {7'h0, it_active}, 8'h00);
      chk("rst_err", {7'h0, it_err}, 8'h00);
      bank_i = 1'b1;
      #1;
      chk("rst_flags_b1", {4'h0, flags_o}, 8'h00);

      // SUBS sets Z in bank 0; flags not visible in the same cycle
      idle_in();
      valid_i = 1'b1; Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11;
      #1;
      chk("subs_condex", {7'h0, CondEx}, 8'h01);
      chk("subs_no_bypass", {4'h0, flags_o}, 8'h00);
      tick();
      idle_in();
      valid_i = 1'b1; Cond = 4'b0000; PCS = 1'b1;
      #1;
      chk("beq_pcsrc", {7'h0, PCSrc}, 8'h01);
      chk("beq_flags", {4'h0, flags_o}, 8'h04);
      tick();

      // Bank isolation: set N in bank 1 only
      idle_in();
      valid_i = 1'b1; bank_i = 1'b1; ALUFlags = 4'b1000; FlagW = 2'b10;
      tick();
      idle_in();
      valid_i = 1'b1; bank_i = 1'b0; Cond = 4'b0100;
      #1;
      chk("b0_mi", {7'h0, CondEx}, 8'h00);
      chk("b0_flags", {4'h0, flags_o}, 8'h04);
      bank_i = 1'b1;
      #1;
      chk("b1_mi", {7'h0, CondEx}, 8'h01);
      chk("b1_flags", {4'h0, flags_o}, 8'h08);
      tick();

      // IT len 3, EQ, mask 101, Z=1 in bank 0
      opener(4'b0000, 3'd3, 4'b0101);
      RegW = 1'b1;
      #1;
      chk("it3_opener_nowrite", {7'h0, RegWrite}, 8'h00);
      tick();
      chk("it3_active", {7'h0, it_active}, 8'h01);
      slot(1'b1);
      #1;
      chk("it3_s1", {7'h0, RegWrite}, 8'h01);
      tick();
      idle_in();
      RegW = 1'b1;
      #1;
      chk("it3_bubble_rw", {7'h0, RegWrite}, 8'h00);
      tick();
      chk("it3_bubble_active", {7'h0, it_active}, 8'h01);
      slot(1'b1);
      #1;
      chk("it3_s2", {7'h0, RegWrite}, 8'h00);
      tick();
      slot(1'b1);
      #1;
      chk("it3_s3", {7'h0, RegWrite}, 8'h01);
      tick();
      chk("it3_done", {7'h0, it_active}, 8'h00);

      // IT len 4, EQ, flags rewritten mid-block
      opener(4'b0000, 3'd4, 4'b1111);
      tick();
      slot(1'b1);
      ALUFlags = 4'b0000; FlagW = 2'b10;
      #1;
      chk("it4_s1", {7'h0, RegWrite}, 8'h01);
      tick();
      slot(1'b1);
      #1;
      chk("it4_s2_newflags", {7'h0, RegWrite}, 8'h00);
      chk("it4_flags", {4'h0, flags_o}, 8'h00);
      tick();
      slot(1'b0);
      tick();
      chk("it4_s3_active", {7'h0, it_active}, 8'h01);
      slot(1'b0);
      tick();
      chk("it4_done", {7'h0, it_active}, 8'h00);

      // Illegal lengths
      opener(4'b1110, 3'd0, 4'b1111);
      tick();
      chk("len0_err", {7'h0, it_err}, 8'h01);
      chk("len0_active", {7'h0, it_active}, 8'h00);
      idle_in();
      tick();
      chk("err_pulse_end", {7'h0, it_err}, 8'h00);
      opener(4'b1110, 3'd5, 4'b1111);
      tick();
      chk("len5_err", {7'h0, it_err}, 8'h01);
      chk("len5_active", {7'h0, it_active}, 8'h00);
      idle_in();
      tick();

      // Nested opener inside a len-2 AL block
      opener(4'b1110, 3'd2, 4'b1111);
      tick();
      slot(1'b1);
      it_start = 1'b1; it_len = 3'd3;
      #1;
      chk("nest_s1", {7'h0, RegWrite}, 8'h01);
      tick();
      chk("nest_err", {7'h0, it_err}, 8'h01);
      chk("nest_active", {7'h0, it_active}, 8'h01);
      slot(1'b1);
      #1;
      chk("nest_s2", {7'h0, RegWrite}, 8'h01);
      tick();
      chk("nest_done", {7'h0, it_active}, 8'h00);

      // Else slot of AL behaves as NV
      opener(4'b1110, 3'd1, 4'b0000);
      tick();
      slot(1'b1);
      #1;
      chk("al_else", {7'h0, RegWrite}, 8'h00);
      tick();
      chk("al_else_done", {7'h0, it_active}, 8'h00);

      // Flush at slot 2 of len 4
      opener(4'b1110, 3'd4, 4'b1111);
      tick();
      slot(1'b1);
      tick();
      slot(1'b1);
      flush = 1'b1; PCS = 1'b1; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
      #1;
      chk("flush_outs", {4'h0, PCSrc, RegWrite, MemWrite, CondEx}, 8'h00);
      tick();
      chk("flush_active", {7'h0, it_active}, 8'h00);
      chk("flush_flags", {4'h0, flags_o}, 8'h00);
      idle_in();
      valid_i = 1'b1; RegW = 1'b1;
      #1;
      chk("post_flush_plain", {7'h0, RegWrite}, 8'h01);
      tick();

      // Taken branch at slot 2 of len 4
      opener(4'b1110, 3'd4, 4'b1111);
      tick();
      slot(1'b0);
      tick();
      slot(1'b0);
      PCS = 1'b1;
      #1;
      chk("br_pcsrc", {7'h0, PCSrc}, 8'h01);
      tick();
      chk("br_active", {7'h0, it_active}, 8'h00);

      // Reset at slot 2 of len 4
      idle_in();
      valid_i = 1'b1; ALUFlags = 4'b0110; FlagW = 2'b11;
      tick();
      chk("pre_rst_flags", {4'h0, flags_o}, 8'h06);
      opener(4'b1110, 3'd4, 4'b1111);
      tick();
      slot(1'b1);
      tick();
      slot(1'b1);
      reset = 1'b1;
      #1;
      chk("rst_mid_rw", {7'h0, RegWrite}, 8'h00);
      tick();
      reset = 1'b0;
      #1;
      chk("rst_mid_active", {7'h0, it_active}, 8'h00);
      chk("rst_mid_flags", {4'h0, flags_o}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
